// File: rtl/sound_controller.sv
// Beep generator: a code edge starts one DUR-clock square-wave beep at a code-specific pitch.
// Optional macro SOUND_TWO_TONE_EN: code 3 plays high tone for the first half, then low tone.
module sound_controller #(
    parameter int HALF_LOW  = 13636,
    parameter int HALF_HIGH = 6818,
    parameter int DUR       = 1200000,
    parameter int CNT_W     = 21
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       sound,
    output logic       busy
);
    localparam int HALF_MAX = (HALF_LOW > HALF_HIGH) ? HALF_LOW : HALF_HIGH;
    localparam int TONE_W   = $clog2(HALF_MAX + 1);

    localparam logic [TONE_W-1:0] LOW_M1  = TONE_W'(HALF_LOW - 1);
    localparam logic [TONE_W-1:0] HIGH_M1 = TONE_W'(HALF_HIGH - 1);
    localparam logic [CNT_W-1:0]  DUR_M1  = CNT_W'(DUR - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        code_q;
    logic [1:0]        cur_code_q, cur_code_d;
    logic [CNT_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;
    logic              sound_q, sound_d;
    logic              busy_q, busy_d;

    logic              trigger;
    logic [1:0]        sel_code;
    logic [TONE_W-1:0] reload_m1;
`ifdef SOUND_TWO_TONE_EN
    logic              sel_hi;
`endif

    assign trigger = (code_sound != code_q) && (code_sound != 2'd0);

    // Reload value is taken from the incoming code on a trigger, else from the playing code.
    always_comb begin
        sel_code  = trigger ? code_sound : cur_code_q;
        reload_m1 = LOW_M1;
`ifdef SOUND_TWO_TONE_EN
        sel_hi = trigger || (dur_cnt_q >= CNT_W'(DUR / 2));
        case (sel_code)
            2'd2:    reload_m1 = HIGH_M1;
            2'd3:    reload_m1 = sel_hi ? HIGH_M1 : LOW_M1;
            default: reload_m1 = LOW_M1;
        endcase
`else
        case (sel_code)
            2'd2:    reload_m1 = HIGH_M1;
            default: reload_m1 = LOW_M1;
        endcase
`endif
    end

    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        busy_d     = busy_q;

        if (trigger) begin
            state_d    = PLAY;
            cur_code_d = code_sound;
            dur_cnt_d  = DUR_M1;
            tone_cnt_d = reload_m1;
            tone_d     = 1'b1;
            busy_d     = 1'b1;
        end else if (state_q == PLAY) begin
            if (dur_cnt_q == '0) begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                tone_d     = 1'b0;
                tone_cnt_d = '0;
            end else begin
                dur_cnt_d = dur_cnt_q - 1'b1;
                if (tone_cnt_q == '0) begin
                    tone_cnt_d = reload_m1;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q - 1'b1;
                end
            end
        end

        // Mute gates only the pin; the tone phase keeps running underneath.
        sound_d = tone_d && !mute && (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            code_q     <= 2'd0;
            cur_code_q <= 2'd0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            sound_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_sound;
            cur_code_q <= cur_code_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            sound_q    <= sound_d;
            busy_q     <= busy_d;
        end
    end

    assign sound = sound_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sound_controller.sv
// Directed bench for sound_controller with HALF_LOW=4, HALF_HIGH=2, DUR=40.
module tb_sound_controller;
    logic       clk;
    logic       clr;
    logic [1:0] code_sound;
    logic       mute;
    logic       sound;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    sound_controller #(
        .HALF_LOW (4),
        .HALF_HIGH(2),
        .DUR      (40),
        .CNT_W    (6)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .code_sound(code_sound),
        .mute      (mute),
        .sound     (sound),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; code_sound = 2'd0; mute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || sound !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d busy=%b sound=%b want 0 0", i, busy, sound);
            end
        end
        clr = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || sound !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b sound=%b want 0 0", busy, sound);
        end
    endtask

    // Low-tone waveform: sound high for k/4 even; code 3 identical in the default build.
    task automatic test_low_beep(input logic [1:0] code);
        logic exp_s;
        code_sound = code;
        for (int k = 0; k <= 40; k++) begin
            tick();
            exp_s = (k < 40) && (((k / 4) % 2) == 0);
            checks++;
            if (busy !== (k < 40) || sound !== exp_s) begin
                failures++;
                $display("FAIL low_beep code=%0d k=%0d busy=%b sound=%b want %b %b",
                         code, k, busy, sound, k < 40, exp_s);
            end
        end
        code_sound = 2'd0;
        tick();
    endtask

    task automatic test_no_retrigger();
        int hi;
        hi = 0;
        code_sound = 2'd1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy === 1'b1) hi++;
        end
        checks++;
        if (hi != 40) begin
            failures++;
            $display("FAIL hold_one_beep busy_cycles=%0d want 40", hi);
        end
        code_sound = 2'd0;
        tick();
        code_sound = 2'd1;
        tick();
        checks++;
        if (busy !== 1'b1 || sound !== 1'b1) begin
            failures++;
            $display("FAIL rearm_start busy=%b sound=%b want 1 1", busy, sound);
        end
        // A drop to 0 mid-beep must not cut the beep short.
        code_sound = 2'd0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (busy !== (k < 40)) begin
                failures++;
                $display("FAIL zero_ignored k=%0d busy=%b want %b", k, busy, k < 40);
            end
        end
    endtask

    task automatic test_retrigger();
        logic exp_s;
        code_sound = 2'd1;
        tick();
        for (int k = 1; k < 10; k++) tick();
        code_sound = 2'd2;
        for (int j = 0; j <= 40; j++) begin
            tick();
            exp_s = (j < 40) && (((j / 2) % 2) == 0);
            checks++;
            if (busy !== (j < 40) || sound !== exp_s) begin
                failures++;
                $display("FAIL retrigger j=%0d busy=%b sound=%b want %b %b",
                         j, busy, sound, j < 40, exp_s);
            end
        end
        code_sound = 2'd0;
        tick();
    endtask

    task automatic test_mute();
        logic exp_s;
        code_sound = 2'd1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            mute = (k >= 8) && (k < 20);
            tick();
            exp_s = (k < 40) && !((k >= 8) && (k < 20)) && (((k / 4) % 2) == 0);
            checks++;
            if (busy !== (k < 40) || sound !== exp_s) begin
                failures++;
                $display("FAIL mute k=%0d busy=%b sound=%b want %b %b",
                         k, busy, sound, k < 40, exp_s);
            end
        end
        mute = 1'b0;
        code_sound = 2'd0;
        tick();
    endtask

    // Trigger landing on the expiry edge restarts a full-length beep.
    task automatic test_expiry_trigger();
        code_sound = 2'd1;
        tick();
        for (int k = 1; k < 40; k++) tick();
        code_sound = 2'd2;
        tick();
        checks++;
        if (busy !== 1'b1 || sound !== 1'b1) begin
            failures++;
            $display("FAIL expiry_trigger busy=%b sound=%b want 1 1", busy, sound);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (busy !== (k < 40)) begin
                failures++;
                $display("FAIL expiry_restart k=%0d busy=%b want %b", k, busy, k < 40);
            end
        end
        code_sound = 2'd0;
        tick();
    endtask

    task automatic test_reset_mid();
        code_sound = 2'd1;
        for (int k = 0; k < 6; k++) tick();
        clr = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || sound !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy=%b sound=%b want 0 0", busy, sound);
        end
        tick();
        clr = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || sound !== 1'b1) begin
            failures++;
            $display("FAIL held_through_reset busy=%b sound=%b want 1 1", busy, sound);
        end
        code_sound = 2'd0;
        for (int k = 0; k < 42; k++) tick();
        checks++;
        if (busy !== 1'b0 || sound !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_beep busy=%b sound=%b want 0 0", busy, sound);
        end
    endtask

`ifdef SOUND_TWO_TONE_EN
    // Toggles every 2 clocks through edge T+22, then every 4 clocks.
    task automatic test_two_tone();
        int   n;
        logic exp_s;
        code_sound = 2'd3;
        for (int k = 0; k <= 40; k++) begin
            tick();
            n = (k <= 22) ? (k / 2) : (11 + (k - 22) / 4);
            exp_s = (k < 40) && ((n % 2) == 0);
            checks++;
            if (busy !== (k < 40) || sound !== exp_s) begin
                failures++;
                $display("FAIL two_tone k=%0d busy=%b sound=%b want %b %b",
                         k, busy, sound, k < 40, exp_s);
            end
        end
        code_sound = 2'd0;
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_low_beep(2'd1);
        test_no_retrigger();
        test_retrigger();
        test_mute();
        test_expiry_trigger();
        test_reset_mid();
`ifdef SOUND_TWO_TONE_EN
        test_two_tone();
`else
        test_low_beep(2'd3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
